// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the data-memory interface
package mem_if_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = WORD_W / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } mem_state_e;

   localparam logic [1:0] ST_IDLE   = S_IDLE;
   localparam logic [1:0] ST_WAIT   = S_WAIT;
   localparam logic [1:0] ST_ACCESS = S_ACCESS;
   localparam logic [1:0] ST_RESP   = S_RESP;

   localparam logic ERR_NONE   = 1'b0;
   localparam logic ERR_ACCESS = 1'b1;

   // Misaligned, or beyond the 2**aw words the bank holds
   function automatic logic addr_err(input logic [31:0] addr, input int aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mem_sram_bank.sv
// rtl/mem_sram_bank.sv - single-port word RAM with per-lane write enables and registered read
module mem_sram_bank
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [BE_W-1:0]       we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_W-1:0]     wdata,
   output logic [WORD_W-1:0]     rdata
);

   logic [WORD_W-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - one-at-a-time load/store responder with wait states over a data SRAM
module data_memory_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [1:0]            state;
   logic [3:0]            wait_cnt;
   logic                  lat_write;
   logic                  lat_err;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [WORD_W-1:0]     lat_wdata;
   logic [BE_W-1:0]       lat_be;
   logic                  sram_en;
   logic [BE_W-1:0]       sram_we;
   logic [WORD_W-1:0]     sram_rdata;

   assign req_ready = rst && (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign sram_en   = (state == ST_ACCESS);
   assign sram_we   = (sram_en && lat_write && !lat_err) ? lat_be : '0;

   mem_sram_bank #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bank (
      .clk  (clk),
      .en   (sram_en),
      .we   (sram_we),
      .addr (lat_idx),
      .wdata(lat_wdata),
      .rdata(sram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= 4'd0;
         lat_write  <= 1'b0;
         lat_err    <= 1'b0;
         lat_idx    <= '0;
         lat_wdata  <= '0;
         lat_be     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= ERR_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_err   <= addr_err(req_addr, ADDR_WIDTH);
                  lat_idx   <= req_addr[ADDR_WIDTH+1:2];
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  wait_cnt  <= WAIT_LOAD;
                  if (WAIT_STATES == 0) state <= ST_ACCESS;
                  else                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) state <= ST_ACCESS;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            ST_ACCESS: state <= ST_RESP;
            default: begin
               // Bank read data lands in the first RESP cycle; capture it, then offer it
               if (!resp_valid) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= (lat_err || lat_write) ? '0 : sram_rdata;
                  resp_err   <= lat_err ? ERR_ACCESS : ERR_NONE;
               end else if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= ERR_NONE;
                  state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench for data_memory_responder
module tb_data_memory_responder;

   localparam int WS = 2;
   localparam int AW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;

   logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_resp_ready = 1'b1;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic [3:0]  z_req_be = '0;
   logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
   logic [31:0] z_resp_rdata;

   int checks = 0;
   int errors = 0;
   bit rand_rr = 1'b0;

   always #5 clk = ~clk;

   data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .busy(busy)
   );

   data_memory_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_z (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
      .resp_err(z_resp_err), .busy(z_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic bit is_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
   endfunction

   // Reference model: word memory with per-byte knowledge, and a countdown to the response
   logic [31:0] mm [int];
   logic [3:0]  mk [int];
   int          ph = 0;       // 0 idle, 1 request in flight, 2 response offered
   int          left = 0;     // edges until resp_valid must be high
   bit          acc_next = 1'b0, take_next = 1'b0;
   bit          e_w, e_err, e_rchk;
   int          e_idx;
   logic [31:0] e_wdata, e_rdata;
   logic [3:0]  e_be;

   always @(negedge clk) begin
      if (!rst) begin
         ph = 0; acc_next = 1'b0; take_next = 1'b0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rdata", resp_rdata, 0);
         chk("rst_err", resp_err, 0);
      end else begin
         if (take_next) begin
            ph = 0; take_next = 1'b0;
         end else if (acc_next) begin
            ph = 1; left = WS + 2; acc_next = 1'b0;
         end else if (ph == 1) begin
            left--;
            if (left == 1 && e_w && !e_err) begin
               if (!mm.exists(e_idx)) begin mm[e_idx] = '0; mk[e_idx] = '0; end
               for (int i = 0; i < 4; i++) begin
                  if (e_be[i]) begin
                     mm[e_idx][8*i +: 8] = e_wdata[8*i +: 8];
                     mk[e_idx][i] = 1'b1;
                  end
               end
            end
            if (left == 0) ph = 2;
         end
         chk("m_resp_valid", resp_valid, (ph == 2));
         chk("m_req_ready", req_ready, (ph == 0));
         chk("m_busy", busy, (ph != 0));
         if (ph == 2) begin
            chk("m_resp_err", resp_err, e_err);
            if (e_rchk) chk("m_resp_rdata", resp_rdata, e_rdata);
         end
         if (ph == 0 && req_valid) begin
            acc_next = 1'b1;
            e_w = req_write; e_err = is_err(req_addr); e_idx = int'(req_addr[AW+1:2]);
            e_wdata = req_wdata; e_be = req_be;
            e_rchk = 1'b1; e_rdata = '0;
            if (!e_w && !e_err) begin
               if (mm.exists(e_idx) && mk[e_idx] == 4'hF) e_rdata = mm[e_idx];
               else e_rchk = 1'b0;
            end
         end else if (ph == 2 && resp_ready) begin
            take_next = 1'b1;
         end
      end
   end

   task automatic send_req(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 100) begin chk("accept_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      forever begin
         @(posedge clk); lat++;
         #1; if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (resp_valid) break;
         if (lat > 100) begin chk("valid_timeout", 0, 1); break; end
      end
   endtask

   task automatic wait_drop();
      int n = 0;
      forever begin
         @(posedge clk); #1;
         if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!resp_valid) break;
         n++;
         if (n > 200) begin chk("drop_timeout", 0, 1); break; end
      end
   endtask

   task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat);
      send_req(w, a, d, be);
      wait_valid(lat);
      rd = resp_rdata; er = resp_err;
      wait_drop();
   endtask

   task automatic zx(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err, input string nm);
      int n = 0;
      @(posedge clk); #1;
      z_req_valid = 1'b1; z_req_write = w; z_req_addr = a; z_req_wdata = d; z_req_be = be;
      @(negedge clk); chk({nm, "_ready"}, z_req_ready, 1);
      @(posedge clk); #1; z_req_valid = 1'b0;
      while (n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (z_resp_valid) break;
      end
      chk({nm, "_lat"}, n, 2);
      chk({nm, "_rdata"}, z_resp_rdata, exp_rd);
      chk({nm, "_err"}, z_resp_err, exp_err);
      @(posedge clk); @(negedge clk);
      chk({nm, "_taken"}, z_resp_valid, 0);
   endtask

   initial begin
      logic [31:0] rd, a;
      logic        er;
      int          lat, r;

      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t1_req_ready", req_ready, 0);
      chk("t1_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); chk("t1_rel_ready", req_ready, 1);

      xact(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      chk("t2_st_lat", lat, WS + 2); chk("t2_st_err", er, 0); chk("t2_st_rdata", rd, 0);
      xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      chk("t2_ld_lat", lat, WS + 2); chk("t2_ld_rdata", rd, 32'hDEADBEEF); chk("t2_ld_err", er, 0);

      xact(1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      chk("t3_ld_rdata", rd, 32'hDEADBEAA);

      xact(1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
      xact(0, 32'h13, 32'h0, 4'h0, rd, er, lat);
      chk("t4_mis_err", er, 1); chk("t4_mis_rdata", rd, 0); chk("t4_mis_lat", lat, WS + 2);
      xact(1, 32'h0004_0000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      chk("t4_oor_err", er, 1);
      xact(0, 32'h0, 32'h0, 4'h0, rd, er, lat);
      chk("t4_w0_rdata", rd, 32'h0BADF00D); chk("t4_w0_err", er, 0);
      xact(1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat);
      chk("t4_be0_err", er, 0);
      xact(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      chk("t4_be0_rdata", rd, 32'hDEADBEAA);

      resp_ready = 1'b0;
      send_req(0, 32'h10, 32'h0, 4'h0);
      wait_valid(lat);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", resp_valid, 1);
         chk("t5_hold_rdata", resp_rdata, 32'hDEADBEAA);
         chk("t5_hold_ready", req_ready, 0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk); chk("t5_take_ready", req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk); chk("t5_idle_ready", req_ready, 1); chk("t5_idle_valid", resp_valid, 0);
      @(posedge clk); #1 req_valid = 1'b0;
      wait_valid(lat);
      chk("t5_next_lat", lat, WS + 2); chk("t5_next_rdata", resp_rdata, 32'h0BADF00D);
      wait_drop();

      xact(1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
      send_req(1, 32'h20, 32'h22222222, 4'hF);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      xact(0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      chk("t6_abort_rdata", rd, 32'h11111111);

      zx(1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "z_st");
      zx(0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "z_ld");
      zx(0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1, "z_mis");

      for (int i = 0; i < 16; i++) xact(1, 32'(i) << 2, $urandom, 4'hF, rd, er, lat);
      rand_rr = 1'b1;
      repeat (200) begin
         r = $urandom_range(0, 9);
         a = 32'($urandom_range(0, 15)) << 2;
         if (r == 0)      a = a | 32'($urandom_range(1, 3));
         else if (r == 1) a = a | (32'($urandom_range(1, 16383)) << 18);
         xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, er, lat);
         chk("rnd_lat", lat, WS + 2);
         chk("rnd_err", er, is_err(a));
      end
      rand_rr = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
